// File: rtl/m68k_fastram_bridge_if.sv
// CPU-pin and SDRAM-controller signal bundle for the fast-RAM bridge.
// master = bridge side, slave = CPU pins plus controller side.
interface m68k_fastram_bridge_if;
   logic [22:0] cpu_addr;
   logic        cpu_as_n;
   logic        cpu_uds_n;
   logic        cpu_lds_n;
   logic        cpu_rw;
   logic [15:0] cpu_data_in;
   logic [15:0] cpu_data_out;
   logic        cpu_data_oe;
   logic        cpu_dtack_n;
   logic        cpu_dtack_oe;
   logic        ram_ena;
   logic        ram_rw;
   logic        ram_u_ena_n;
   logic        ram_l_ena_n;
   logic        ram_ready;
   logic [21:0] ram_addr;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;

   modport master (
      input  cpu_addr, cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw, cpu_data_in,
             ram_ready, ram_rdata,
      output cpu_data_out, cpu_data_oe, cpu_dtack_n, cpu_dtack_oe,
             ram_ena, ram_rw, ram_u_ena_n, ram_l_ena_n, ram_addr, ram_wdata
   );

   modport slave (
      output cpu_addr, cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw, cpu_data_in,
             ram_ready, ram_rdata,
      input  cpu_data_out, cpu_data_oe, cpu_dtack_n, cpu_dtack_oe,
             ram_ena, ram_rw, ram_u_ena_n, ram_l_ena_n, ram_addr, ram_wdata
   );
endinterface

// File: rtl/m68k_fastram_bridge.sv
// 68000 bus to fast-RAM controller bridge: one level-handshake request per CPU cycle in the 8 MB window.
// AS pin to ram_ena is SYNC_STAGES+2 clocks; ram_ena holds until ready, DTACK holds until AS negates.
module m68k_fastram_bridge #(
   parameter logic [23:0] BASE        = 24'h200000,
   parameter int          SYNC_STAGES = 2
) (
   input logic                   clk,
   input logic                   reset_n,
   m68k_fastram_bridge_if.master bus
);

   typedef enum logic [2:0] {IDLE, STROBE, REQ, ACK, RELEASE} state_t;

   // Per stage: {rw, lds_n, uds_n, as_n}
   logic [SYNC_STAGES-1:0][3:0] sync_q;
   logic as_s, uds_s, lds_s, rw_s;

   state_t      state_q, state_d;
   logic        ram_ena_q, ram_ena_d;
   logic        ram_rw_q, ram_rw_d;
   logic        u_ena_n_q, u_ena_n_d;
   logic        l_ena_n_q, l_ena_n_d;
   logic [21:0] ram_addr_q, ram_addr_d;
   logic [15:0] ram_wdata_q, ram_wdata_d;
   logic [15:0] dout_q, dout_d;
   logic        doe_q, doe_d;
   logic        dtack_oe_q, dtack_oe_d;

   logic [23:0] word_off;
   logic        hit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '1;
      end else begin
         sync_q[0] <= {bus.cpu_rw, bus.cpu_lds_n, bus.cpu_uds_n, bus.cpu_as_n};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign as_s  = sync_q[SYNC_STAGES-1][0];
   assign uds_s = sync_q[SYNC_STAGES-1][1];
   assign lds_s = sync_q[SYNC_STAGES-1][2];
   assign rw_s  = sync_q[SYNC_STAGES-1][3];

   // Word offset from BASE; a borrow (bit 23) or an offset of 8 MB or more (bit 22) is a miss.
   assign word_off = {1'b0, bus.cpu_addr} - {1'b0, BASE[23:1]};
   assign hit      = ~word_off[23] & ~word_off[22];

   always_comb begin
      state_d     = state_q;
      ram_ena_d   = ram_ena_q;
      ram_rw_d    = ram_rw_q;
      u_ena_n_d   = u_ena_n_q;
      l_ena_n_d   = l_ena_n_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      dout_d      = dout_q;
      doe_d       = doe_q;
      dtack_oe_d  = dtack_oe_q;
      case (state_q)
         IDLE: begin
            if (!as_s && hit) begin
               ram_addr_d = word_off[21:0];
               ram_rw_d   = rw_s;
               state_d    = STROBE;
            end
         end
         STROBE: begin
            if (as_s) begin
               state_d = IDLE;
            end else if ((!uds_s || !lds_s) && !bus.ram_ready) begin
               u_ena_n_d   = uds_s;
               l_ena_n_d   = lds_s;
               ram_wdata_d = bus.cpu_data_in;
               ram_ena_d   = 1'b1;
               state_d     = REQ;
            end
         end
         REQ: begin
            if (bus.ram_ready) begin
               if (ram_rw_q) begin
                  dout_d = bus.ram_rdata;
               end
               dtack_oe_d = 1'b1;
               doe_d      = ram_rw_q;
               state_d    = ACK;
            end
         end
         ACK: begin
            if (as_s) begin
               dtack_oe_d = 1'b0;
               doe_d      = 1'b0;
               ram_ena_d  = 1'b0;
               state_d    = RELEASE;
            end
         end
         RELEASE: begin
            // A pending AS stays low for the whole CPU cycle, so it is picked up in IDLE.
            if (!bus.ram_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         ram_ena_q   <= 1'b0;
         ram_rw_q    <= 1'b1;
         u_ena_n_q   <= 1'b1;
         l_ena_n_q   <= 1'b1;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         dout_q      <= '0;
         doe_q       <= 1'b0;
         dtack_oe_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ram_ena_q   <= ram_ena_d;
         ram_rw_q    <= ram_rw_d;
         u_ena_n_q   <= u_ena_n_d;
         l_ena_n_q   <= l_ena_n_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         dout_q      <= dout_d;
         doe_q       <= doe_d;
         dtack_oe_q  <= dtack_oe_d;
      end
   end

   assign bus.ram_ena      = ram_ena_q;
   assign bus.ram_rw       = ram_rw_q;
   assign bus.ram_u_ena_n  = u_ena_n_q;
   assign bus.ram_l_ena_n  = l_ena_n_q;
   assign bus.ram_addr     = ram_addr_q;
   assign bus.ram_wdata    = ram_wdata_q;
   assign bus.cpu_data_out = dout_q;
   assign bus.cpu_data_oe  = doe_q;
   assign bus.cpu_dtack_n  = 1'b0;
   assign bus.cpu_dtack_oe = dtack_oe_q;

endmodule

// File: tb/tb_m68k_fastram_bridge.sv
// Directed bench for m68k_fastram_bridge with a small level-handshake controller model.
module tb_m68k_fastram_bridge;
   logic clk = 1'b0;
   logic reset_n = 1'b0;

   m68k_fastram_bridge_if bus();

   m68k_fastram_bridge #(.BASE(24'h200000), .SYNC_STAGES(2)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #10 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Controller model: ready rdy_delay clocks after ena, dropped rdy_hold+1 clocks after ena falls
   int          rdy_delay = 7;
   int          rdy_hold  = 0;
   int          ena_cnt   = 0;
   int          hold_cnt  = 0;
   logic [15:0] rdata_v   = 16'hBEEF;
   assign bus.ram_rdata = rdata_v;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.ram_ready <= 1'b0;
         ena_cnt       <= 0;
         hold_cnt      <= 0;
      end else if (bus.ram_ena) begin
         hold_cnt <= 0;
         if (!bus.ram_ready) begin
            if (ena_cnt >= rdy_delay - 1) bus.ram_ready <= 1'b1;
            ena_cnt <= ena_cnt + 1;
         end
      end else begin
         ena_cnt <= 0;
         if (bus.ram_ready) begin
            if (hold_cnt >= rdy_hold) bus.ram_ready <= 1'b0;
            else hold_cnt <= hold_cnt + 1;
         end
      end
   end

   logic ena_prev = 1'b0;
   int   reqs = 0;
   int   dbl  = 0;
   always @(negedge clk) begin
      if (bus.ram_ena && !ena_prev) begin
         reqs++;
         if (bus.ram_ready) dbl++;
      end
      ena_prev = bus.ram_ena;
   end

   logic        s_ena, s_dtack, s_doe;
   int          t_ena, t_rdy, t_dtack, t_rel;
   logic [21:0] c_addr;
   logic        c_rw, c_u, c_l, c_doe, c_ena_rel, c_doe_rel;
   logic [15:0] c_wd, c_dout;

   task automatic run_cycle(input logic [23:0] a, input logic rw, input logic u_n,
                            input logic l_n, input logic [15:0] wd, input int ds_lag,
                            input int limit);
      s_ena = 0; s_dtack = 0; s_doe = 0;
      t_ena = -1; t_rdy = -1; t_dtack = -1; t_rel = -1;
      c_ena_rel = 1'b1; c_doe_rel = 1'b1;
      @(negedge clk);
      bus.cpu_addr    = a[23:1];
      bus.cpu_rw      = rw;
      bus.cpu_data_in = wd;
      bus.cpu_as_n    = 1'b0;
      if (ds_lag == 0) begin
         bus.cpu_uds_n = u_n;
         bus.cpu_lds_n = l_n;
      end
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (bus.ram_ena && !s_ena) begin
            s_ena = 1; t_ena = i;
            c_addr = bus.ram_addr; c_rw = bus.ram_rw;
            c_u = bus.ram_u_ena_n; c_l = bus.ram_l_ena_n; c_wd = bus.ram_wdata;
         end
         if (bus.ram_ready && t_rdy < 0) t_rdy = i;
         if (bus.cpu_data_oe) s_doe = 1;
         if (bus.cpu_dtack_oe) begin
            s_dtack = 1; t_dtack = i;
            c_dout = bus.cpu_data_out; c_doe = bus.cpu_data_oe;
            break;
         end
         if (i == ds_lag) begin
            bus.cpu_uds_n = u_n;
            bus.cpu_lds_n = l_n;
         end
      end
      bus.cpu_as_n  = 1'b1;
      bus.cpu_uds_n = 1'b1;
      bus.cpu_lds_n = 1'b1;
      if (s_dtack) begin
         for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (!bus.cpu_dtack_oe) begin
               t_rel = i; c_ena_rel = bus.ram_ena; c_doe_rel = bus.cpu_data_oe;
               break;
            end
         end
      end
   endtask

   task automatic settle();
      int n;
      n = 0;
      while (bus.ram_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_drop", {31'd0, bus.ram_ready}, 32'd0);
      repeat (3) @(negedge clk);
   endtask

   int base_reqs;

   initial begin
      bus.cpu_addr = '0; bus.cpu_as_n = 1'b1; bus.cpu_uds_n = 1'b1; bus.cpu_lds_n = 1'b1;
      bus.cpu_rw = 1'b1; bus.cpu_data_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_ena",      bus.ram_ena,      0);
      chk("rst_rw",       bus.ram_rw,       1);
      chk("rst_uen",      bus.ram_u_ena_n,  1);
      chk("rst_len",      bus.ram_l_ena_n,  1);
      chk("rst_addr",     bus.ram_addr,     0);
      chk("rst_wdata",    bus.ram_wdata,    0);
      chk("rst_dout",     bus.cpu_data_out, 0);
      chk("rst_doe",      bus.cpu_data_oe,  0);
      chk("rst_dtack_oe", bus.cpu_dtack_oe, 0);
      chk("dtack_level",  bus.cpu_dtack_n,  0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Word read at window base
      run_cycle(24'h200000, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 40);
      chk("rd_ena_lat",   t_ena, 4);
      chk("rd_addr",      c_addr, 22'h000000);
      chk("rd_rw",        c_rw, 1);
      chk("rd_uen",       c_u, 0);
      chk("rd_len",       c_l, 0);
      chk("rd_rdy_lat",   t_rdy - t_ena, 7);
      chk("rd_dtack_lat", t_dtack - t_rdy, 1);
      chk("rd_dout",      c_dout, 16'hBEEF);
      chk("rd_doe",       c_doe, 1);
      chk("rd_rel_lat",   t_rel, 3);
      chk("rd_rel_ena",   c_ena_rel, 0);
      chk("rd_rel_doe",   c_doe_rel, 0);
      settle();

      // Lower-byte write at the top word of the window, DS lagging AS by 3 clocks
      run_cycle(24'h9FFFFE, 1'b0, 1'b1, 1'b0, 16'h00A5, 3, 40);
      chk("wr_dtack",   s_dtack, 1);
      chk("wr_ena_lat", t_ena, 6);
      chk("wr_addr",    c_addr, 22'h3FFFFF);
      chk("wr_rw",      c_rw, 0);
      chk("wr_uen",     c_u, 1);
      chk("wr_len",     c_l, 0);
      chk("wr_wdata",   c_wd, 16'h00A5);
      chk("wr_doe",     s_doe, 0);
      settle();

      // Just below and just above the window
      run_cycle(24'h1FFFFE, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 30);
      chk("lo_ena",   s_ena, 0);
      chk("lo_dtack", s_dtack, 0);
      chk("lo_doe",   s_doe, 0);
      repeat (4) @(negedge clk);
      run_cycle(24'hA00000, 1'b0, 1'b0, 1'b0, 16'h1234, 0, 30);
      chk("hi_ena",   s_ena, 0);
      chk("hi_dtack", s_dtack, 0);
      chk("hi_doe",   s_doe, 0);
      repeat (4) @(negedge clk);

      // Aborted cycle: AS without any data strobe
      run_cycle(24'h300000, 1'b1, 1'b0, 1'b0, 16'h0000, 1000, 10);
      repeat (5) @(negedge clk);
      chk("abort_ena", s_ena | bus.ram_ena, 0);

      // Back-to-back reads with ready held 4 clocks after ena drops
      rdy_hold  = 4;
      base_reqs = reqs;
      rdata_v   = 16'h1111;
      run_cycle(24'h400000, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 40);
      chk("b2b_dout0", c_dout, 16'h1111);
      rdata_v = 16'h2222;
      run_cycle(24'h400002, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 60);
      chk("b2b_dtack1", s_dtack, 1);
      chk("b2b_dout1",  c_dout, 16'h2222);
      chk("b2b_addr1",  c_addr, 22'h100001);
      settle();
      chk("b2b_reqs",   reqs - base_reqs, 2);
      chk("b2b_double", dbl, 0);
      rdy_hold = 0;

      // Reset pulse while DTACK is driven
      rdata_v = 16'h5A5A;
      @(negedge clk);
      bus.cpu_addr = 23'h100000; bus.cpu_rw = 1'b1;
      bus.cpu_as_n = 1'b0; bus.cpu_uds_n = 1'b0; bus.cpu_lds_n = 1'b0;
      begin
         int n;
         n = 0;
         while (!bus.cpu_dtack_oe && n < 40) begin
            @(negedge clk);
            n++;
         end
      end
      chk("mid_dtack_seen", bus.cpu_dtack_oe, 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_dtack_oe", bus.cpu_dtack_oe, 0);
      chk("mid_rst_doe",      bus.cpu_data_oe,  0);
      chk("mid_rst_ena",      bus.ram_ena,      0);
      chk("mid_rst_dout",     bus.cpu_data_out, 0);
      @(negedge clk);
      bus.cpu_as_n = 1'b1; bus.cpu_uds_n = 1'b1; bus.cpu_lds_n = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      rdata_v = 16'hCAFE;
      run_cycle(24'h200010, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 40);
      chk("post_rst_ena_lat", t_ena, 4);
      chk("post_rst_addr",    c_addr, 22'h000008);
      chk("post_rst_dout",    c_dout, 16'hCAFE);
      chk("post_rst_rel",     t_rel, 3);
      settle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
